irda_fir_tx_seq: RTL and testbench

Frame-level sequencer for the FIR (4PPM) transmit path. It drives the flag generator's start/flag-select inputs to emit N x PA, then STA, then hands off to the data path, then STO. It tracks flag-generator end-of-flag and a data-done handshake, and reports busy, done and abort status to the UART/FIR register block.

---
 rtl/irda_fir_tx_seq.sv | 159 +++++++++++++++
 tb/tb_irda_fir_tx_seq.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/irda_fir_tx_seq.sv
// FIR (4PPM) transmit frame sequencer: N x PA, STA, payload handoff, STO.
// Optional WAIT-state watchdog enabled by defining IRDA_FIR_SEQ_TIMEOUT_EN.
module irda_fir_tx_seq #(
  parameter int unsigned PA_CNT_W  = 5,
  parameter int unsigned TMO_LIMIT = 64
) (
  input  logic                clk,
  input  logic                wb_rst_n_i,
  input  logic                fir_tx4_enable,
  input  logic                fir_tx8_enable,
  input  logic                tx_start_i,
  input  logic                tx_abort_i,
  input  logic [PA_CNT_W-1:0] pa_reps_i,
  input  logic                data_done_i,
  input  logic                eof_i,
  output logic                fir_gen_start,
  output logic [1:0]          fir_flag,
  output logic                data_phase_o,
  output logic                data_start_o,
  output logic                busy_o,
  output logic                frame_done_o,
  output logic                frame_abort_o
`ifdef IRDA_FIR_SEQ_TIMEOUT_EN
  ,
  output logic                seq_err_o
`endif
);

  typedef enum logic [2:0] {
    IDLE, PA_ARM, PA_WAIT, STA_ARM, STA_WAIT, DATA, STO_ARM, STO_WAIT
  } state_t;

  localparam logic [1:0] FLAG_NONE = 2'b00;
  localparam logic [1:0] FLAG_PA   = 2'b01;
  localparam logic [1:0] FLAG_STA  = 2'b10;
  localparam logic [1:0] FLAG_STO  = 2'b11;

  state_t              state;
  logic [PA_CNT_W-1:0] pa_left;
  logic                eof_d;
  logic                eof_rise;
  logic                in_arm;
  logic                in_wait;
  logic                user_abort;
  logic                timed_out;
  logic                kill;

  assign eof_rise   = eof_i & ~eof_d;
  assign in_arm     = (state == PA_ARM) || (state == STA_ARM) || (state == STO_ARM);
  assign in_wait    = (state == PA_WAIT) || (state == STA_WAIT) || (state == STO_WAIT);
  assign user_abort = (state != IDLE) && tx_abort_i;
  assign busy_o     = (state != IDLE);

`ifdef IRDA_FIR_SEQ_TIMEOUT_EN
  localparam logic [6:0] TMO = 7'(TMO_LIMIT);
  logic [6:0] tmo_cnt;

  // An eof_rise arriving in the same cycle the limit is hit still completes the flag.
  assign timed_out = in_wait && (tmo_cnt == TMO) && !eof_rise;

  always_ff @(posedge clk or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      tmo_cnt   <= '0;
      seq_err_o <= 1'b0;
    end else begin
      seq_err_o <= timed_out && !user_abort;
      if (in_arm && fir_tx4_enable)
        tmo_cnt <= '0;
      else if (in_wait && fir_tx8_enable && (tmo_cnt != TMO))
        tmo_cnt <= tmo_cnt + 7'd1;
    end
  end
`else
  assign timed_out = 1'b0;
`endif

  assign kill = user_abort || timed_out;

  always_ff @(posedge clk or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state         <= IDLE;
      pa_left       <= '0;
      eof_d         <= 1'b0;
      fir_gen_start <= 1'b0;
      fir_flag      <= FLAG_NONE;
      data_phase_o  <= 1'b0;
      data_start_o  <= 1'b0;
      frame_done_o  <= 1'b0;
      frame_abort_o <= 1'b0;
    end else begin
      eof_d         <= eof_i;
      data_start_o  <= 1'b0;
      frame_done_o  <= 1'b0;
      frame_abort_o <= 1'b0;
      if (kill) begin
        state         <= IDLE;
        fir_flag      <= FLAG_NONE;
        fir_gen_start <= 1'b0;
        data_phase_o  <= 1'b0;
        frame_abort_o <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (tx_start_i) begin
              pa_left       <= (pa_reps_i == '0) ? PA_CNT_W'(1) : pa_reps_i;
              fir_flag      <= FLAG_PA;
              fir_gen_start <= 1'b1;
              state         <= PA_ARM;
            end
          end
          PA_ARM, STA_ARM, STO_ARM: begin
            if (fir_tx4_enable) begin
              fir_gen_start <= 1'b0;
              state <= (state == PA_ARM)  ? PA_WAIT :
                       (state == STA_ARM) ? STA_WAIT : STO_WAIT;
            end
          end
          PA_WAIT: begin
            if (eof_rise) begin
              fir_gen_start <= 1'b1;
              if (pa_left > PA_CNT_W'(1)) begin
                pa_left <= pa_left - PA_CNT_W'(1);
                state   <= PA_ARM;
              end else begin
                fir_flag <= FLAG_STA;
                state    <= STA_ARM;
              end
            end
          end
          STA_WAIT: begin
            if (eof_rise) begin
              fir_flag     <= FLAG_NONE;
              data_phase_o <= 1'b1;
              data_start_o <= 1'b1;
              state        <= DATA;
            end
          end
          DATA: begin
            if (data_done_i) begin
              data_phase_o  <= 1'b0;
              fir_flag      <= FLAG_STO;
              fir_gen_start <= 1'b1;
              state         <= STO_ARM;
            end
          end
          STO_WAIT: begin
            if (eof_rise) begin
              fir_flag     <= FLAG_NONE;
              frame_done_o <= 1'b1;
              state        <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_irda_fir_tx_seq.sv
// Self-checking bench for irda_fir_tx_seq: a flag-generator/data-path model
// records every accepted flag and the frame is compared to the expected PA..STA..STO list.
module tb_irda_fir_tx_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx4, tx8, tx_start, tx_abort, data_done, eof;
  logic [4:0] pa_reps;
  logic       gen_start, data_phase, data_start, busy, frame_done, frame_abort;
  logic [1:0] flag;
`ifdef IRDA_FIR_SEQ_TIMEOUT_EN
  logic       seq_err;
`endif

  irda_fir_tx_seq #(.PA_CNT_W(5), .TMO_LIMIT(64)) dut (
    .clk(clk), .wb_rst_n_i(rst_n), .fir_tx4_enable(tx4), .fir_tx8_enable(tx8),
    .tx_start_i(tx_start), .tx_abort_i(tx_abort), .pa_reps_i(pa_reps),
    .data_done_i(data_done), .eof_i(eof), .fir_gen_start(gen_start),
    .fir_flag(flag), .data_phase_o(data_phase), .data_start_o(data_start),
    .busy_o(busy), .frame_done_o(frame_done), .frame_abort_o(frame_abort)
`ifdef IRDA_FIR_SEQ_TIMEOUT_EN
    , .seq_err_o(seq_err)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_err = 0;
  int unsigned cyc = 0;
  bit auto_gen = 1'b1, rnd_strobe = 1'b0;
  logic gen_eof = 1'b0, man_eof = 1'b0;
  bit gen_act = 1'b0;
  int gen_cnt = 0, hold = 0;
  int ds_cnt = 0, fd_cnt = 0, ab_cnt = 0, se_cnt = 0;
  bit last_acc = 1'b0;
  logic [1:0] last_flag = 2'b00;
  bit dd_arm = 1'b0;
  int dd_wait = 0, dd_hold = 0;
  logic [1:0] log_q[$];

  assign eof = auto_gen ? gen_eof : man_eof;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: accept/eof model of the flag generator, payload model, strobes.
  task automatic tick();
    bit acc, t8;
    logic [1:0] fl;
    acc = gen_start && tx4;
    fl  = flag;
    t8  = tx8;
    @(posedge clk); #1;
    cyc++;
    last_acc  = acc;
    last_flag = fl;
    if (acc) log_q.push_back(fl);
    if (auto_gen) begin
      if (acc) begin
        gen_act = 1'b1; gen_cnt = 2 + int'($urandom % 4); gen_eof = 1'b0; hold = 0;
      end else if (gen_act && t8) begin
        gen_cnt--;
        if (gen_cnt == 0) begin gen_act = 1'b0; gen_eof = 1'b1; hold = 1 + int'($urandom % 3); end
      end else if (gen_eof) begin
        hold--;
        if (hold == 0) gen_eof = 1'b0;
      end
    end
    if (data_start) begin
      ds_cnt++;
      check("phase_at_start", data_phase, 1);
    end
    if (frame_done) begin
      fd_cnt++;
      check("busy_at_done", {busy, flag}, 0);
    end
    if (frame_abort) ab_cnt++;
`ifdef IRDA_FIR_SEQ_TIMEOUT_EN
    if (seq_err) se_cnt++;
`endif
    if (auto_gen) begin
      if (data_start) begin dd_arm = 1'b1; dd_wait = int'($urandom % 5); end
      if (dd_arm) begin
        if (dd_wait == 0) begin dd_arm = 1'b0; data_done = 1'b1; dd_hold = 1 + int'($urandom % 2); end
        else dd_wait--;
      end else if (data_done) begin
        dd_hold--;
        if (dd_hold <= 0) data_done = 1'b0;
      end
    end
    if (rnd_strobe) begin
      tx4 = ($urandom % 3) == 0;
      tx8 = ($urandom % 4) == 0;
    end else begin
      tx4 = (cyc % 2) == 0;
      tx8 = (cyc % 4) == 0;
    end
  endtask

  task automatic clear_counts();
    log_q.delete();
    ds_cnt = 0; fd_cnt = 0; ab_cnt = 0; se_cnt = 0;
  endtask

  task automatic wait_accept(input string tag, input logic [1:0] exp);
    bit got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      tick();
      got = last_acc;
    end
    check({tag, "_accepted"}, got, 1);
    check({tag, "_flag"}, last_flag, exp);
  endtask

  task automatic run_frame(input int pa);
    int pa_eff;
    bit done = 1'b0;
    clear_counts();
    pa_reps = 5'(pa);
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    check("start_latency", {gen_start, flag, busy}, {1'b1, 2'b01, 1'b1});
    for (int i = 0; i < 4000 && !done; i++) begin
      tick();
      done = (fd_cnt != 0);
    end
    check("frame_completes", done, 1);
    pa_eff = (pa == 0) ? 1 : pa;
    check("flag_count", log_q.size(), pa_eff + 2);
    for (int i = 0; i < log_q.size(); i++)
      check("flag_seq", log_q[i], (i < pa_eff) ? 1 : (i == pa_eff) ? 2 : 3);
    check("pulse_counts", {8'(ds_cnt), 8'(fd_cnt), 8'(ab_cnt)}, {8'd1, 8'd1, 8'd0});
    repeat (4) tick();
    data_done = 1'b0; dd_arm = 1'b0;
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0; tx4 = 1'b0; tx8 = 1'b0; tx_start = 1'b0; tx_abort = 1'b0;
    data_done = 1'b0; pa_reps = '0;
    repeat (3) tick();
    check("reset_outs", {gen_start, flag, data_phase, data_start, busy, frame_done, frame_abort}, 0);
    rst_n = 1'b1;
    tick();
    check("idle_outs", {gen_start, flag, busy}, 0);

    run_frame(3);
    run_frame(0);
    for (int f = 0; f < 6; f++) begin
      rnd_strobe = f[0];
      run_frame(int'($urandom % 8));
    end
    rnd_strobe = 1'b0;

    // Abort in the second PA_WAIT, then a clean frame.
    clear_counts();
    pa_reps = 5'd3; tx_start = 1'b1; tick(); tx_start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      tick();
      seen = (log_q.size() == 2) && !gen_start;
    end
    check("second_pa_wait", seen, 1);
    tx_abort = 1'b1; tick(); tx_abort = 1'b0;
    check("abort_outs", {flag, busy, gen_start, frame_abort}, {2'b00, 1'b0, 1'b0, 1'b1});
    tick();
    check("abort_pulse_len", {frame_abort, busy}, 0);
    repeat (20) tick();
    check("abort_counts", {8'(ab_cnt), 8'(fd_cnt)}, {8'd1, 8'd0});
    run_frame(2);

    // Abort in IDLE with a coincident start is ignored.
    clear_counts();
    tx_abort = 1'b1; tx_start = 1'b1; tick(); tx_abort = 1'b0; tx_start = 1'b0;
    check("idle_abort_start", {busy, frame_abort}, {1'b1, 1'b0});
    tx_abort = 1'b1; tick(); tx_abort = 1'b0;
    check("abort_after_idle_start", {busy, frame_abort}, {1'b0, 1'b1});
    tick();

    // Held eof in STA_WAIT and data_done during the data_start cycle.
    auto_gen = 1'b0; man_eof = 1'b0; clear_counts();
    pa_reps = 5'd1; tx_start = 1'b1; tick(); tx_start = 1'b0;
    wait_accept("t4_pa", 2'b01);
    man_eof = 1'b1; tick(); man_eof = 1'b0;
    check("pa_to_sta", {flag, gen_start}, {2'b10, 1'b1});
    wait_accept("t4_sta", 2'b10);
    man_eof = 1'b1; tick();
    check("sta_to_data", {data_start, data_phase, flag}, {1'b1, 1'b1, 2'b00});
    data_done = 1'b1; tick(); data_done = 1'b0;
    check("done_in_start_cycle", {data_start, data_phase, flag, gen_start}, {1'b0, 1'b0, 2'b11, 1'b1});
    repeat (10) tick();
    check("held_eof_no_rise", {8'(ds_cnt), 8'(fd_cnt), 7'd0, busy}, {8'd1, 8'd0, 7'd0, 1'b1});
    check("sto_accepted", {gen_start, log_q[log_q.size()-1]}, {1'b0, 2'b11});
    man_eof = 1'b0; tick(); man_eof = 1'b1; tick();
    check("sto_done", {frame_done, busy, flag}, {1'b1, 1'b0, 2'b00});
    man_eof = 1'b0; tick();

    // Start while busy ignored; abort beats a coincident eof_rise.
    clear_counts();
    pa_reps = 5'd2; tx_start = 1'b1; tick(); tx_start = 1'b0;
    wait_accept("t5_pa", 2'b01);
    tx_start = 1'b1; tick(); tx_start = 1'b0;
    check("start_while_busy", {flag, gen_start, busy}, {2'b01, 1'b0, 1'b1});
    man_eof = 1'b1; tx_abort = 1'b1; tick(); tx_abort = 1'b0;
    check("abort_beats_eof", {frame_abort, busy, flag, gen_start}, {1'b1, 1'b0, 2'b00, 1'b0});
    man_eof = 1'b0; tick();
    check("start_not_queued", {busy, frame_abort}, 0);

`ifdef IRDA_FIR_SEQ_TIMEOUT_EN
    clear_counts();
    pa_reps = 5'd1; tx_start = 1'b1; tick(); tx_start = 1'b0;
    wait_accept("tmo_pa", 2'b01);
    seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      tick();
      seen = frame_abort;
    end
    check("tmo_abort", {seen, seq_err, busy}, {1'b1, 1'b1, 1'b0});
    tick();
    check("tmo_pulse_len", {seq_err, frame_abort, 6'(se_cnt)}, {1'b0, 1'b0, 6'd1});
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
